vlan_tag_sequencer: RTL and testbench
=====================================

Name: vlan_tag_sequencer

Overview:
Sequential L2 header walker for the Ethernet parser. It consumes the frame byte stream, counts header bytes and detects up to MAX_TAGS stacked VLAN tags (802.1Q / 802.1ad). It emits one result record per frame: VLAN presence, outer and inner VLAN IDs, resolved ethertype and L2 header length. It then drains the rest of the frame. Its output feeds the same downstream consumers as the combinational VLAN resolver stage, and replaces that stage's fixed 14-byte assumption.

Parameters:
MAX_TAGS, 2, maximum VLAN tags parsed (legal 0..2); a TPID found beyond this count is reported as the resolved ethertype
TPID_QINQ, 16'h88A8, service-tag TPID
TPID_DOT1Q, 16'h8100, customer-tag TPID

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  byte valid
in_ready  out  1  byte accepted when in_valid && in_ready
in_data  in  8  frame byte, network order
in_sof  in  1  first byte of frame (qualified by in_valid)
in_eof  in  1  last byte of frame (qualified by in_valid)
res_valid  out  1  result record valid
res_ready  in  1  result consumed when res_valid && res_ready
vlan_present  out  1  at least one tag parsed
vlan_count  out  2  number of tags parsed (0..2)
outer_vlan_id  out  12  VID of first tag, 0 if none
inner_vlan_id  out  12  VID of second tag, 0 if fewer than 2
resolved_ethertype  out  16  ethertype after the last parsed tag
l2_header_len  out  5  14 + 4*vlan_count, or bytes seen on runt
hdr_error  out  1  runt: eof before header complete

Behaviour:
- Reset: clk/rst synchronous, active-high. All outputs are 0, except l2_header_len=0 and in_ready=0 during the reset cycle. State=IDLE. Reset mid-frame discards the partial frame and any pending result.
- States:
  - IDLE: in_ready=1. A beat with in_sof moves to MAC; byte_cnt is set to 1. A beat without sof is dropped and the FSM stays in IDLE.
  - MAC: accepts bytes 1..11. After byte 11 the FSM goes to ETYPE.
  - ETYPE: 2 bytes, captured MSB first into etype_reg.
    - If etype_reg equals TPID_QINQ or TPID_DOT1Q and tag_cnt<MAX_TAGS, go to TCI.
    - Otherwise the header is complete: go to RESULT.
  - TCI: 2 bytes. VID = {byte0[3:0], byte1}. The VID is written to outer_vlan_id if tag_cnt==0, otherwise to inner_vlan_id. Then tag_cnt++ and go to ETYPE.
  - RESULT: in_ready=0 and res_valid=1; all fields held stable until res_ready.
    - On handshake: go to DRAIN if in_eof has not yet been seen, else IDLE.
  - DRAIN: in_ready=1; bytes are discarded. A beat with in_eof goes to IDLE.
- Latency: res_valid asserts in the cycle after the last ethertype byte is accepted.
- byte_cnt: 5 bits and saturates at 31. l2_header_len equals byte_cnt at header completion (14/18/22).
- Runt: in_eof accepted in MAC, ETYPE or TCI goes directly to RESULT with hdr_error=1.
  - l2_header_len = bytes accepted.
  - resolved_ethertype=0; the VIDs already captured are retained.
  - After the handshake the FSM goes to IDLE; no DRAIN.
- eof on the final ethertype byte: the frame is complete and not an error. The eof is remembered, and the FSM returns to IDLE after the result handshake.
- sof while not in IDLE is a protocol violation. The frame is aborted: the FSM restarts in MAC with byte_cnt=1 and the previous partial header is dropped. No result is emitted for the aborted frame. Exception: in RESULT in_ready=0, so the sof beat is not consumed.
- res_ready held high: the result is consumed in its first cycle. Back-pressure on in_ready is therefore exactly 1 cycle per frame.
- tag_cnt never exceeds MAX_TAGS. With MAX_TAGS=0 every frame reports vlan_present=0 and len=14.
- Output fields are registered and change only on entry to RESULT or on reset.

Test Plan:
- Untagged frame, ethertype 0x0800, 64 B, res_ready=1 -> vlan_present=0, vlan_count=0, resolved_ethertype=0x0800, len=14, hdr_error=0; res_valid for 1 cycle after byte 13; remaining 50 bytes drained.
- Single tag: 0x8100, TCI 0xA07B, then 0x86DD -> vlan_count=1, outer_vlan_id=0x07B, inner=0, ethertype=0x86DD, len=18.
- QinQ: 0x88A8/TCI 0x0064, then 0x8100/TCI 0x00C8, then 0x0800 -> vlan_count=2, outer=100, inner=200, ethertype=0x0800, len=22. Triple tag with MAX_TAGS=2 -> ethertype=0x8100, len=22.
- Runt: 10-byte frame with eof on byte 9 -> hdr_error=1, len=10, ethertype=0; next frame parses normally.
- Back-pressure: res_ready held low 5 cycles -> in_ready=0 and all outputs stable for 5 cycles; after the handshake the drain continues with no byte lost.
- Reset: rst asserted during a TCI byte -> next cycle all outputs 0 and state IDLE; the following frame is parsed correctly with no stale VIDs.

Source files
------------

// File: rtl/vlan_tag_sequencer.sv
// Byte-serial L2 header walker: counts header bytes, peels up to MAX_TAGS stacked
// VLAN tags and emits one result record per frame before draining the payload.
//
// state  | meaning
// IDLE   | waiting for a start-of-frame beat
// MAC    | destination/source MAC bytes 1..11
// ETYPE  | two ethertype/TPID bytes, MSB first
// TCI    | two tag-control bytes, VID captured from the low 12 bits
// RESULT | record presented, input stalled until res_ready
// DRAIN  | discarding payload until end of frame
module vlan_tag_sequencer #(
    parameter int          MAX_TAGS   = 2,
    parameter logic [15:0] TPID_QINQ  = 16'h88A8,
    parameter logic [15:0] TPID_DOT1Q = 16'h8100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        vlan_present,
    output logic [1:0]  vlan_count,
    output logic [11:0] outer_vlan_id,
    output logic [11:0] inner_vlan_id,
    output logic [15:0] resolved_ethertype,
    output logic [4:0]  l2_header_len,
    output logic        hdr_error
);

    localparam logic [1:0] MAX_TAGS_C = 2'(MAX_TAGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_ETYPE,
        S_TCI,
        S_RESULT,
        S_DRAIN
    } state_t;

    state_t      state_q;
    logic [4:0]  byte_cnt_q;
    logic [4:0]  byte_cnt_d;
    logic [1:0]  tag_cnt_q;
    logic [7:0]  hi_byte_q;
    logic [11:0] outer_q;
    logic [11:0] inner_q;
    logic        eof_seen_q;

    logic        in_ready_q;
    logic        res_valid_q;
    logic        vlan_present_q;
    logic [1:0]  vlan_count_q;
    logic [11:0] outer_vlan_id_q;
    logic [11:0] inner_vlan_id_q;
    logic [15:0] resolved_ethertype_q;
    logic [4:0]  l2_header_len_q;
    logic        hdr_error_q;

    logic        accept;
    logic [15:0] etype_d;
    logic [11:0] vid_d;
    logic        tag_next;
    logic        sof_restart;
    logic        hdr_beat;
    logic        hdr_done;
    logic        runt;
    logic        res_load;
    logic [4:0]  res_len_d;
    logic [1:0]  res_count_d;
    logic [11:0] res_outer_d;
    logic [11:0] res_inner_d;

    assign accept = in_valid && in_ready_q;

    // Header fields are 2-byte aligned, so byte_cnt[0] marks the second byte of a pair.
    always_comb begin
        byte_cnt_d  = (byte_cnt_q == 5'd31) ? byte_cnt_q : byte_cnt_q + 5'd1;
        etype_d     = {hi_byte_q, in_data};
        vid_d       = {hi_byte_q[3:0], in_data};
        tag_next    = ((etype_d == TPID_QINQ) || (etype_d == TPID_DOT1Q))
                      && (tag_cnt_q < MAX_TAGS_C);
        sof_restart = accept && in_sof;
        hdr_beat    = accept && !in_sof && (state_q inside {S_MAC, S_ETYPE, S_TCI});
        hdr_done    = hdr_beat && (state_q == S_ETYPE) && byte_cnt_q[0] && !tag_next;
        runt        = (sof_restart && in_eof) || (hdr_beat && in_eof && !hdr_done);
        res_load    = hdr_done || runt;
        res_len_d   = sof_restart ? 5'd1  : byte_cnt_d;
        res_count_d = sof_restart ? 2'd0  : tag_cnt_q;
        res_outer_d = sof_restart ? 12'd0 : outer_q;
        res_inner_d = sof_restart ? 12'd0 : inner_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= S_IDLE;
            byte_cnt_q           <= 5'd0;
            tag_cnt_q            <= 2'd0;
            hi_byte_q            <= 8'd0;
            outer_q              <= 12'd0;
            inner_q              <= 12'd0;
            eof_seen_q           <= 1'b0;
            in_ready_q           <= 1'b0;
            res_valid_q          <= 1'b0;
            vlan_present_q       <= 1'b0;
            vlan_count_q         <= 2'd0;
            outer_vlan_id_q      <= 12'd0;
            inner_vlan_id_q      <= 12'd0;
            resolved_ethertype_q <= 16'd0;
            l2_header_len_q      <= 5'd0;
            hdr_error_q          <= 1'b0;
        end else begin
            in_ready_q <= 1'b1;
            if (sof_restart) begin
                byte_cnt_q <= 5'd1;
                tag_cnt_q  <= 2'd0;
                outer_q    <= 12'd0;
                inner_q    <= 12'd0;
                eof_seen_q <= in_eof;
                state_q    <= S_MAC;
            end else if (accept) begin
                byte_cnt_q <= byte_cnt_d;
                case (state_q)
                    S_MAC: begin
                        if (byte_cnt_q == 5'd11) state_q <= S_ETYPE;
                    end
                    S_ETYPE: begin
                        if (!byte_cnt_q[0]) hi_byte_q <= in_data;
                        else if (tag_next)  state_q <= S_TCI;
                        else                eof_seen_q <= in_eof;
                    end
                    S_TCI: begin
                        if (!byte_cnt_q[0]) begin
                            hi_byte_q <= in_data;
                        end else begin
                            if (tag_cnt_q == 2'd0) outer_q <= vid_d;
                            else                   inner_q <= vid_d;
                            tag_cnt_q <= tag_cnt_q + 2'd1;
                            state_q   <= S_ETYPE;
                        end
                    end
                    S_DRAIN: begin
                        if (in_eof) state_q <= S_IDLE;
                    end
                    default: ;
                endcase
            end

            if (res_load) begin
                state_q              <= S_RESULT;
                in_ready_q           <= 1'b0;
                res_valid_q          <= 1'b1;
                vlan_present_q       <= (res_count_d != 2'd0);
                vlan_count_q         <= res_count_d;
                outer_vlan_id_q      <= res_outer_d;
                inner_vlan_id_q      <= res_inner_d;
                resolved_ethertype_q <= runt ? 16'd0 : etype_d;
                l2_header_len_q      <= res_len_d;
                hdr_error_q          <= runt;
                if (runt) eof_seen_q <= 1'b1;
            end else if (state_q == S_RESULT) begin
                if (res_ready) begin
                    res_valid_q <= 1'b0;
                    state_q     <= eof_seen_q ? S_IDLE : S_DRAIN;
                end else begin
                    in_ready_q <= 1'b0;
                end
            end
        end
    end

    assign in_ready           = in_ready_q;
    assign res_valid          = res_valid_q;
    assign vlan_present       = vlan_present_q;
    assign vlan_count         = vlan_count_q;
    assign outer_vlan_id      = outer_vlan_id_q;
    assign inner_vlan_id      = inner_vlan_id_q;
    assign resolved_ethertype = resolved_ethertype_q;
    assign l2_header_len      = l2_header_len_q;
    assign hdr_error          = hdr_error_q;

endmodule

// File: tb/tb_vlan_tag_sequencer.sv
// Scoreboard bench for vlan_tag_sequencer: directed frames push expected records,
// an independent monitor pops and compares on each result handshake.
module tb_vlan_tag_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        in_sof = 1'b0;
    logic        in_eof = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic        vlan_present;
    logic [1:0]  vlan_count;
    logic [11:0] outer_vlan_id;
    logic [11:0] inner_vlan_id;
    logic [15:0] resolved_ethertype;
    logic [4:0]  l2_header_len;
    logic        hdr_error;

    vlan_tag_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .in_sof             (in_sof),
        .in_eof             (in_eof),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .vlan_present       (vlan_present),
        .vlan_count         (vlan_count),
        .outer_vlan_id      (outer_vlan_id),
        .inner_vlan_id      (inner_vlan_id),
        .resolved_ethertype (resolved_ethertype),
        .l2_header_len      (l2_header_len),
        .hdr_error          (hdr_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int stall_cnt = 0;

    logic [48:0] exp_q[$];
    logic [7:0]  fq[$];
    logic [48:0] got_rec;

    assign got_rec = {vlan_present, vlan_count, outer_vlan_id, inner_vlan_id,
                      resolved_ethertype, l2_header_len, hdr_error};

    function automatic logic [48:0] rec(input logic p, input logic [1:0] c,
                                        input logic [11:0] o, input logic [11:0] i,
                                        input logic [15:0] e, input logic [4:0] l,
                                        input logic err);
        return {p, c, o, i, e, l, err};
    endfunction

    // Monitor: byte/stall accounting and scoreboard pop on each result handshake.
    initial begin
        logic [48:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (in_valid && in_ready)  acc_cnt++;
                if (in_valid && !in_ready) stall_cnt++;
                if (res_valid && res_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL result_unexpected got=%h required=none", got_rec);
                    end else begin
                        e = exp_q.pop_front();
                        if (got_rec !== e) begin
                            errors++;
                            $display("FAIL result_record got=%h required=%h", got_rec, e);
                        end
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        in_eof   = e;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got=0 required=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic mac();
        for (int i = 0; i < 12; i++) fq.push_back(8'h20 + 8'(i));
    endtask

    task automatic p16(input logic [15:0] v);
        fq.push_back(v[15:8]);
        fq.push_back(v[7:0]);
    endtask

    task automatic pad_to(input int n);
        while (fq.size() < n) fq.push_back(8'(fq.size()));
    endtask

    task automatic run_frame(input int hdr_end, input logic do_eof, input int exp_stall);
        int a0 = acc_cnt;
        int s0 = stall_cnt;
        int n  = fq.size();
        for (int i = 0; i < n; i++) begin
            send_byte(fq[i], i == 0, do_eof && (i == n - 1));
            if (i == hdr_end) begin
                checks++;
                if (res_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency got=%0b required=1", res_valid);
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (acc_cnt - a0 != n) begin
            errors++;
            $display("FAIL bytes_accepted got=%0d required=%0d", acc_cnt - a0, n);
        end
        checks++;
        if (stall_cnt - s0 != exp_stall) begin
            errors++;
            $display("FAIL stall_cycles got=%0d required=%0d", stall_cnt - s0, exp_stall);
        end
        fq.delete();
    endtask

    task automatic bp_hold(input logic [48:0] e);
        int n = 0;
        @(negedge clk);
        while (!res_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({in_ready, res_valid, got_rec} !== {1'b0, 1'b1, e}) begin
                errors++;
                $display("FAIL backpressure_hold cycle=%0d got=%b_%b_%h required=0_1_%h",
                         k, in_ready, res_valid, got_rec, e);
            end
            if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
    endtask

    initial begin
        logic [48:0] e;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({res_valid, in_ready, got_rec} !== 51'd0) begin
            errors++;
            $display("FAIL reset_state got=%b_%b_%h required=0_0_0", res_valid, in_ready, got_rec);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Untagged 64-byte frame
        mac(); p16(16'h0800); pad_to(64);
        exp_q.push_back(rec(0, 2'd0, 12'h000, 12'h000, 16'h0800, 5'd14, 0));
        run_frame(13, 1'b1, 1);

        // Single 802.1Q tag
        mac(); p16(16'h8100); p16(16'hA07B); p16(16'h86DD); pad_to(24);
        exp_q.push_back(rec(1, 2'd1, 12'h07B, 12'h000, 16'h86DD, 5'd18, 0));
        run_frame(17, 1'b1, 1);

        // QinQ
        mac(); p16(16'h88A8); p16(16'h0064); p16(16'h8100); p16(16'h00C8); p16(16'h0800); pad_to(30);
        exp_q.push_back(rec(1, 2'd2, 12'd100, 12'd200, 16'h0800, 5'd22, 0));
        run_frame(21, 1'b1, 1);

        // Third tag beyond MAX_TAGS is reported as the ethertype
        mac(); p16(16'h88A8); p16(16'h0001); p16(16'h8100); p16(16'h0002);
        p16(16'h8100); p16(16'h0003); p16(16'h0800); pad_to(26);
        exp_q.push_back(rec(1, 2'd2, 12'h001, 12'h002, 16'h8100, 5'd22, 0));
        run_frame(21, 1'b1, 1);

        // Runt: 10 bytes, eof on byte 9
        for (int i = 0; i < 10; i++) fq.push_back(8'h40 + 8'(i));
        exp_q.push_back(rec(0, 2'd0, 12'h000, 12'h000, 16'h0000, 5'd10, 1));
        run_frame(9, 1'b1, 0);

        // Normal frame after runt, maximum VID
        mac(); p16(16'h8100); p16(16'hEFFF); p16(16'h0806); pad_to(20);
        exp_q.push_back(rec(1, 2'd1, 12'hFFF, 12'h000, 16'h0806, 5'd18, 0));
        run_frame(17, 1'b1, 1);

        // Back-pressure: res_ready low for 5 result cycles
        res_ready = 1'b0;
        mac(); p16(16'h8100); p16(16'h3005); p16(16'h88CC); pad_to(30);
        e = rec(1, 2'd1, 12'h005, 12'h000, 16'h88CC, 5'd18, 0);
        exp_q.push_back(e);
        fork
            run_frame(17, 1'b1, 6);
            bp_hold(e);
        join
        res_ready = 1'b1;

        // Reset during a TCI byte
        mac(); p16(16'h8100); fq.push_back(8'h0A);
        for (int i = 0; i < fq.size(); i++) send_byte(fq[i], i == 0, 1'b0);
        fq.delete();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hBC;
        @(posedge clk);
        #1;
        checks++;
        if ({res_valid, in_ready, got_rec} !== 51'd0) begin
            errors++;
            $display("FAIL reset_mid_frame got=%b_%b_%h required=0_0_0", res_valid, in_ready, got_rec);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mac(); p16(16'h0806); pad_to(20);
        exp_q.push_back(rec(0, 2'd0, 12'h000, 12'h000, 16'h0806, 5'd14, 0));
        run_frame(13, 1'b1, 1);

        // Partial frame aborted by a new sof: no record for the partial one
        for (int i = 0; i < 6; i++) fq.push_back(8'h60 + 8'(i));
        run_frame(-1, 1'b0, 0);
        mac(); p16(16'h8100); p16(16'h0123); p16(16'h0800); pad_to(20);
        exp_q.push_back(rec(1, 2'd1, 12'h123, 12'h000, 16'h0800, 5'd18, 0));
        run_frame(17, 1'b1, 1);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
